// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop,
// then checks the device ACK. Lines are open-drain; *_oe=1 pulls the pin low.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 20000,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] dbg_state
);

    // Handshake: a byte is taken on any rising clk edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE, so tx_valid is ignored for the whole transfer.

    localparam int CYC_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int INH_CYC = INHIBIT_US * CYC_US;
    localparam int TO_CYC  = TIMEOUT_US * CYC_US;
    localparam int MAX_CYC = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam int FW      = $clog2(FILT_LEN + 1);

    localparam logic [TW-1:0] INH_LAST   = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] START_LAST = TW'(CYC_US - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TO_CYC - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_BITS      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] tmr;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          fall;
    logic          timeout;

    assign dbg_state = state;

    // Idle bus level is high, so the synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1  <= ps2_clk_i;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_i;
            data_s2 <= data_s1;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall    = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);
    assign timeout = ((state == S_BITS) || (state == S_ACK) || (state == S_WAIT_IDLE))
                     && (tmr == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            tmr         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Timeout outranks any bus event landing in the same cycle.
            if (timeout) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                err         <= 1'b1;
                err_code    <= 2'b01;
                tx_ready    <= 1'b1;
                tmr         <= '0;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            shreg      <= tx_data;
                            parity     <= ~^tx_data;
                            bit_cnt    <= '0;
                            tmr        <= '0;
                            err_code   <= 2'b00;
                            tx_ready   <= 1'b0;
                            ps2_clk_oe <= 1'b1;
                            state      <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (tmr == INH_LAST) begin
                            tmr         <= '0;
                            ps2_data_oe <= 1'b1;
                            state       <= S_START;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    S_START: begin
                        if (tmr == START_LAST) begin
                            tmr        <= '0;
                            ps2_clk_oe <= 1'b0;
                            state      <= S_BITS;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    S_BITS: begin
                        tmr <= tmr + 1'b1;
                        if (fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                ps2_data_oe <= ~shreg[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~parity;
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        tmr <= tmr + 1'b1;
                        if (fall) begin
                            if (!data_s2) begin
                                state <= S_WAIT_IDLE;
                            end else begin
                                err      <= 1'b1;
                                err_code <= 2'b10;
                                tx_ready <= 1'b1;
                                tmr      <= '0;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        tmr <= tmr + 1'b1;
                        if (filt_clk && data_s2) begin
                            done     <= 1'b1;
                            err_code <= 2'b00;
                            tx_ready <= 1'b1;
                            tmr      <= '0;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host, collects the bits
// and compares them with a queue of expected frames; done/err outcomes are checked per transfer.
module tb_ps2_host_tx;

    localparam int CYC_US  = 4;
    localparam int INH_CYC = 100 * CYC_US;
    localparam int TO_CYC  = 2000 * CYC_US;
    localparam int HALF    = 20;

    logic       clk;
    logic       rstn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    logic dev_clk_low;
    logic dev_data_low;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ(4_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (2000),
        .FILT_LEN   (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_rel = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int ev_cnt = 0;
    int ev_cyc = 0;
    logic       ev_done = 1'b0;
    logic       ev_err = 1'b0;
    logic [1:0] ev_code = 2'b00;
    logic       ev_rdy = 1'b0;
    logic [1:0] ev_oe = 2'b00;

    logic [9:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn && tx_valid && tx_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (rstn && (done || err)) begin
            ev_cnt  <= ev_cnt + 1;
            ev_cyc  <= cyc;
            ev_done <= done;
            ev_err  <= err;
            ev_code <= err_code;
            ev_rdy  <= tx_ready;
            ev_oe   <= {ps2_clk_oe, ps2_data_oe};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic send(input logic [7:0] d, input logic par);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, par, d});
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom_range(0, 255));
        chk("ready_after_accept", tx_ready, 0);
    endtask

    task automatic rts();
        int n_clk;
        int n_dat;
        n_clk = 0;
        n_dat = 0;
        while (ps2_clk_oe && n_clk < INH_CYC + CYC_US + 50) begin
            if (ps2_data_oe) n_dat++;
            n_clk++;
            @(negedge clk);
        end
        chk("inhibit_len", n_clk, INH_CYC + CYC_US);
        chk("start_len", n_dat, CYC_US);
        chk("start_bit", ps2_data_oe, 1);
        t_rel = cyc;
    endtask

    task automatic dev_run(input int n_edges, input bit ack, input bit glitch,
                           output logic [10:0] bits);
        bits = '1;
        repeat (30) @(negedge clk);
        for (int i = 0; i < n_edges; i++) begin
            dev_clk_low = 1'b1;
            if (ack && i == 10) dev_data_low = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                if (glitch && k == 8) dev_clk_low = 1'b0;
                if (glitch && k == 10) dev_clk_low = 1'b1;
                @(negedge clk);
            end
            bits[i] = ps2_data_i;
            dev_clk_low = 1'b0;
            for (int k = 0; k < HALF; k++) begin
                if (glitch && k == 8) dev_clk_low = 1'b1;
                if (glitch && k == 10) dev_clk_low = 1'b0;
                @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    // scoreboard
    task automatic check_frame(input logic [10:0] bits);
        logic [9:0] e;
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame", bits[9:0], e);
        end
    endtask

    task automatic wait_event(input int c0, input int budget);
        int n;
        n = 0;
        while (ev_cnt == c0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("event_seen", ev_cnt != c0, 1);
    endtask

    task automatic run_ok(input logic [7:0] d, input logic par, input bit glitch);
        logic [10:0] bits;
        int c0;
        send(d, par);
        rts();
        c0 = ev_cnt;
        dev_run(11, 1'b1, glitch, bits);
        check_frame(bits);
        wait_event(c0, 200);
        chk("ok_done", ev_done, 1);
        chk("ok_err", ev_err, 0);
        chk("ok_code", ev_code, 2'b00);
        chk("ok_ready", ev_rdy, 1);
        chk("ok_oe", ev_oe, 2'b00);
    endtask

    initial begin
        logic [10:0] bits;
        int c0;
        int a1;
        rstn         = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("rst_done_err", {done, err}, 2'b00);
        chk("rst_code", err_code, 2'b00);
        chk("rst_state", dbg_state, 3'd0);
        rstn = 1'b1;
        @(negedge clk);

        // byte table with independently worked-out odd parity
        run_ok(8'hED, 1'b1, 1'b0);
        run_ok(8'h07, 1'b0, 1'b0);
        run_ok(8'hFF, 1'b1, 1'b0);
        run_ok(8'h00, 1'b1, 1'b0);

        // silent device: timeout counted from clock release
        send(8'h3C, 1'b1);
        rts();
        c0 = ev_cnt;
        wait_event(c0, TO_CYC + 100);
        chk("to_err", ev_err, 1);
        chk("to_done", ev_done, 0);
        chk("to_code", ev_code, 2'b01);
        chk("to_time", ev_cyc - t_rel, TO_CYC);
        chk("to_oe", ev_oe, 2'b00);
        chk("to_ready", ev_rdy, 1);
        repeat (5) @(negedge clk);
        chk("to_code_hold", err_code, 2'b01);
        exp_q.delete();

        // device clocks the frame but never ACKs
        send(8'hA5, 1'b1);
        rts();
        c0 = ev_cnt;
        dev_run(11, 1'b0, 1'b0, bits);
        check_frame(bits);
        wait_event(c0, 200);
        chk("nack_err", ev_err, 1);
        chk("nack_code", ev_code, 2'b10);
        chk("nack_ready", ev_rdy, 1);

        // reset in the middle of the data bits
        send(8'h55, 1'b1);
        rts();
        dev_run(4, 1'b0, 1'b0, bits);
        chk("mid_state", dbg_state, 3'd3);
        c0 = ev_cnt;
        rstn = 1'b0;
        #1;
        chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_event", ev_cnt, c0);
        chk("rst_ready2", tx_ready, 1);
        exp_q.delete();
        run_ok(8'hF4, 1'b0, 1'b0);

        // glitchy clock while tx_valid stays high with the next byte
        @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 8'h5A});
        @(negedge clk);
        chk("hold_ready", tx_ready, 0);
        tx_data = 8'hC3;
        exp_q.push_back({1'b1, 1'b1, 8'hC3});
        a1 = acc_cnt;
        rts();
        c0 = ev_cnt;
        dev_run(11, 1'b1, 1'b1, bits);
        check_frame(bits);
        wait_event(c0, 200);
        chk("glitch_done", ev_done, 1);
        chk("hold_no_accept", acc_cnt, a1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("hold_accept2", acc_cnt, a1 + 1);
        chk("hold_accept_cyc", acc_cyc, ev_cyc);
        chk("hold_ready2", tx_ready, 0);
        rts();
        c0 = ev_cnt;
        dev_run(11, 1'b1, 1'b0, bits);
        check_frame(bits);
        wait_event(c0, 200);
        chk("second_done", ev_done, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
